// File: rtl/sorted_list_pkg.sv
// Shared types and constants for the sorted-list controller.
//   op_t    : command opcodes (INSERT/POP/DELETE/CLEAR)
//   state_t : controller FSM states
//   rsp_t   : response payload {ok, key}, sized for the default key width
//   ERR_*   : reject cause codes reported on o_err_cause (SORTED_LIST_ERR_EN builds)
package sorted_list_pkg;

    localparam int KEY_W = 16;

    typedef enum logic [1:0] {
        OP_INSERT = 2'd0,
        OP_POP    = 2'd1,
        OP_DELETE = 2'd2,
        OP_CLEAR  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PIVOT  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_RSP    = 2'd3
    } state_t;

    typedef struct packed {
        logic             ok;
        logic [KEY_W-1:0] key;
    } rsp_t;

    localparam logic [1:0] ERR_INS_FULL  = 2'd0;
    localparam logic [1:0] ERR_POP_EMPTY = 2'd1;
    localparam logic [1:0] ERR_DEL_RANGE = 2'd2;

endpackage

// File: rtl/sorted_list_ctrl_if.sv
// Command/response bus of the sorted-list controller.
//   i_cmd_vld/i_cmd_op/i_cmd_key/i_cmd_idx, o_cmd_rdy : command channel
//   o_rsp_vld/o_rsp_ok/o_rsp_key, i_rsp_rdy            : response channel
// master = requester (scheduler front-end), slave = sorted_list_ctrl.
interface sorted_list_ctrl_if #(
    parameter int N  = 8,
    parameter int KW = 16
) ();
    logic                 i_cmd_vld;
    logic [1:0]           i_cmd_op;
    logic [KW-1:0]        i_cmd_key;
    logic [$clog2(N)-1:0] i_cmd_idx;
    logic                 o_cmd_rdy;
    logic                 o_rsp_vld;
    logic                 i_rsp_rdy;
    logic                 o_rsp_ok;
    logic [KW-1:0]        o_rsp_key;

    modport master (
        output i_cmd_vld, i_cmd_op, i_cmd_key, i_cmd_idx, i_rsp_rdy,
        input  o_cmd_rdy, o_rsp_vld, o_rsp_ok, o_rsp_key
    );

    modport slave (
        input  i_cmd_vld, i_cmd_op, i_cmd_key, i_cmd_idx, i_rsp_rdy,
        output o_cmd_rdy, o_rsp_vld, o_rsp_ok, o_rsp_key
    );
endinterface

// File: rtl/sorted_list_pivot.sv
// Combinational insertion-pivot finder.
//   keys/vld  : current table contents and thermometer validity
//   key       : key being inserted
//   count     : number of valid entries (fallback pivot)
//   pivot_idx : lowest index whose valid key is strictly greater than key,
//               or count when no such entry exists (keeps equal keys stable)
module sorted_list_pivot
    import sorted_list_pkg::*;
#(
    parameter int N  = 8,
    parameter int KW = 16,
    parameter int CW = $clog2(N+1)
) (
    input  logic [N-1:0][KW-1:0] keys,
    input  logic [N-1:0]         vld,
    input  logic [KW-1:0]        key,
    input  logic [CW-1:0]        count,
    output logic [CW-1:0]        pivot_idx
);

    logic [N-1:0]  gt_s;
    logic [N-1:0]  oh_s;
    logic [CW-1:0] enc_s;

    // Compare, isolate the lowest "greater" entry as one-hot, encode it
    always_comb begin
        for (int i = 0; i < N; i++) begin
            gt_s[i] = vld[i] & (keys[i] > key);
        end
        // x & -x keeps only the lowest set bit
        oh_s  = gt_s & (~gt_s + {{(N-1){1'b0}}, 1'b1});
        enc_s = '0;
        for (int i = 0; i < N; i++) begin
            enc_s = enc_s | (oh_s[i] ? CW'(i) : {CW{1'b0}});
        end
        pivot_idx = (|gt_s) ? enc_s : count;
    end

endmodule

// File: rtl/sorted_list_ctrl.sv
// Controller for an N-entry ascending-sorted key table (entry 0 = smallest).
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   bus (slave)          : command/response channel (see sorted_list_ctrl_if)
//   o_head_vld/o_head_key: entry 0 (key forced to 0 when empty)
//   o_count/o_full/o_empty: occupancy
//   o_err/o_err_cause    : sticky first-reject flag and cause, present only
//                          when SORTED_LIST_ERR_EN is defined
// Flow: IDLE -> PIVOT -> COMMIT -> RSP -> IDLE (CLEAR skips PIVOT).
module sorted_list_ctrl
    import sorted_list_pkg::*;
#(
    parameter int N  = 8,
    parameter int KW = KEY_W
) (
    input  logic                   clk,
    input  logic                   rst,
    sorted_list_ctrl_if.slave      bus,
    output logic                   o_head_vld,
    output logic [KW-1:0]          o_head_key,
    output logic [$clog2(N+1)-1:0] o_count,
    output logic                   o_full,
    output logic                   o_empty
`ifdef SORTED_LIST_ERR_EN
    ,
    output logic                   o_err,
    output logic [1:0]             o_err_cause
`endif
);

    localparam int CW = $clog2(N+1);
    localparam int IW = $clog2(N);

    state_t                state_q, state_d;
    op_t                   op_q, op_d;
    logic [KW-1:0]         key_q, key_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         pivot_q, pivot_d;
    logic                  ok_q, ok_d;
    logic [N-1:0][KW-1:0]  keys_q, keys_d;
    logic [N-1:0]          vld_q, vld_d;
    logic [CW-1:0]         count_q, count_d;
    rsp_t                  rsp_q, rsp_d;
    logic                  head_vld_q, head_vld_d;
    logic [KW-1:0]         head_key_q, head_key_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;

    logic [CW-1:0]         ins_pivot_s;
    logic [N-1:0][KW-1:0]  keys_up_s;
    logic [N-1:0][KW-1:0]  keys_dn_s;
    logic [KW-1:0]         del_key_s;
    int                    p_s;
    int                    c_s;

    sorted_list_pivot #(.N(N), .KW(KW), .CW(CW)) u_pivot (
        .keys      (keys_q),
        .vld       (vld_q),
        .key       (key_q),
        .count     (count_q),
        .pivot_idx (ins_pivot_s)
    );

    // Whole table shifted one slot up (insert) or down (remove)
    assign keys_up_s = {keys_q[N-2:0], {KW{1'b0}}};
    assign keys_dn_s = {{KW{1'b0}}, keys_q[N-1:1]};

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_cmd_vld) begin
                    state_d = (op_t'(bus.i_cmd_op) == OP_CLEAR) ? ST_COMMIT : ST_PIVOT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PIVOT:  state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_RSP;
            ST_RSP: begin
                if (bus.i_rsp_rdy) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RSP;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // Command capture at acceptance; later bus changes are ignored
    always_comb begin
        op_d  = op_q;
        key_d = key_q;
        idx_d = idx_q;
        if (state_q == ST_IDLE && bus.i_cmd_vld) begin
            op_d  = op_t'(bus.i_cmd_op);
            key_d = bus.i_cmd_key;
            idx_d = bus.i_cmd_idx;
        end else begin
            op_d  = op_q;
            key_d = key_q;
            idx_d = idx_q;
        end
    end

    // Pivot stage: choose pivot index and decide accept/reject
    always_comb begin
        pivot_d = pivot_q;
        ok_d    = ok_q;
        if (state_q == ST_PIVOT) begin
            case (op_q)
                OP_INSERT: begin
                    pivot_d = ins_pivot_s;
                    ok_d    = (count_q != CW'(N));
                end
                OP_POP: begin
                    pivot_d = '0;
                    ok_d    = (count_q != '0);
                end
                OP_DELETE: begin
                    pivot_d = CW'(idx_q);
                    ok_d    = (CW'(idx_q) < count_q);
                end
                default: begin
                    pivot_d = '0;
                    ok_d    = 1'b1;
                end
            endcase
        end else begin
            pivot_d = pivot_q;
            ok_d    = ok_q;
        end
    end

    // Commit stage: shift the key array, update validity/count, form response
    always_comb begin
        p_s       = int'(pivot_q);
        c_s       = int'(count_q);
        del_key_s = '0;
        for (int i = 0; i < N; i++) begin
            del_key_s = (i == p_s) ? keys_q[i] : del_key_s;
        end
        keys_d  = keys_q;
        vld_d   = vld_q;
        count_d = count_q;
        rsp_d   = rsp_q;
        if (state_q == ST_COMMIT) begin
            rsp_d = '0;
            if (op_q == OP_CLEAR) begin
                vld_d    = '0;
                count_d  = '0;
                rsp_d.ok = 1'b1;
            end else if (!ok_q) begin
                rsp_d.ok = 1'b0;
            end else if (op_q == OP_INSERT) begin
                for (int i = 0; i < N; i++) begin
                    if (i == p_s) begin
                        keys_d[i] = key_q;
                    end else if (i > p_s && i <= c_s) begin
                        keys_d[i] = keys_up_s[i];
                    end else begin
                        keys_d[i] = keys_q[i];
                    end
                end
                vld_d    = {vld_q[N-2:0], 1'b1};
                count_d  = count_q + CW'(1);
                rsp_d.ok = 1'b1;
            end else begin
                // POP / DELETE: close the gap and zero the vacated last entry
                for (int i = 0; i < N; i++) begin
                    if (i >= p_s && i < c_s - 1) begin
                        keys_d[i] = keys_dn_s[i];
                    end else if (i == c_s - 1) begin
                        keys_d[i] = '0;
                    end else begin
                        keys_d[i] = keys_q[i];
                    end
                end
                vld_d     = {1'b0, vld_q[N-1:1]};
                count_d   = count_q - CW'(1);
                rsp_d.ok  = 1'b1;
                rsp_d.key = del_key_s;
            end
        end else if (state_q == ST_RSP && bus.i_rsp_rdy) begin
            rsp_d = '0;
        end else begin
            rsp_d = rsp_q;
        end
    end

    // Status outputs follow the table, landing the cycle after COMMIT
    always_comb begin
        head_vld_d = vld_d[0];
        head_key_d = vld_d[0] ? keys_d[0] : {KW{1'b0}};
        full_d     = (count_d == CW'(N));
        empty_d    = (count_d == '0);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_INSERT;
            key_q      <= '0;
            idx_q      <= '0;
            pivot_q    <= '0;
            ok_q       <= 1'b0;
            keys_q     <= '0;
            vld_q      <= '0;
            count_q    <= '0;
            rsp_q      <= '0;
            head_vld_q <= 1'b0;
            head_key_q <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            key_q      <= key_d;
            idx_q      <= idx_d;
            pivot_q    <= pivot_d;
            ok_q       <= ok_d;
            keys_q     <= keys_d;
            vld_q      <= vld_d;
            count_q    <= count_d;
            rsp_q      <= rsp_d;
            head_vld_q <= head_vld_d;
            head_key_q <= head_key_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
        end
    end

    assign bus.o_cmd_rdy = (state_q == ST_IDLE);
    assign bus.o_rsp_vld = (state_q == ST_RSP);
    assign bus.o_rsp_ok  = rsp_q.ok;
    assign bus.o_rsp_key = rsp_q.key;
    assign o_head_vld    = head_vld_q;
    assign o_head_key    = head_key_q;
    assign o_count       = count_q;
    assign o_full        = full_q;
    assign o_empty       = empty_q;

`ifdef SORTED_LIST_ERR_EN
    logic       err_q, err_d;
    logic [1:0] err_cause_q, err_cause_d;
    logic [1:0] cause_s;
    logic       reject_s;

    // Reject cause for the command in COMMIT
    always_comb begin
        case (op_q)
            OP_INSERT: cause_s = ERR_INS_FULL;
            OP_POP:    cause_s = ERR_POP_EMPTY;
            default:   cause_s = ERR_DEL_RANGE;
        endcase
    end

    // Sticky error: first reject wins, CLEAR wipes it
    always_comb begin
        reject_s    = (state_q == ST_COMMIT) && (op_q != OP_CLEAR) && !ok_q;
        err_d       = err_q;
        err_cause_d = err_cause_q;
        if (state_q == ST_COMMIT && op_q == OP_CLEAR) begin
            err_d       = 1'b0;
            err_cause_d = 2'd0;
        end else if (reject_s && !err_q) begin
            err_d       = 1'b1;
            err_cause_d = cause_s;
        end else begin
            err_d       = err_q;
            err_cause_d = err_cause_q;
        end
    end

    // Error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q       <= 1'b0;
            err_cause_q <= 2'd0;
        end else begin
            err_q       <= err_d;
            err_cause_q <= err_cause_d;
        end
    end

    assign o_err       = err_q;
    assign o_err_cause = err_cause_q;
`else
    // Rejects are visible only through o_rsp_ok in this build.
`endif

endmodule

// File: tb/tb_sorted_list_ctrl.sv
// Self-checking bench for sorted_list_ctrl: directed vector table, hand-written
// corner sequences (full reject, back-pressure, reset mid-command, CLEAR) and a
// randomized run checked against a queue-based reference model.
module tb_sorted_list_ctrl;
    import sorted_list_pkg::*;

    localparam int N  = 8;
    localparam int KW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          head_vld;
    logic [KW-1:0] head_key;
    logic [3:0]    count;
    logic          full;
    logic          empty;
`ifdef SORTED_LIST_ERR_EN
    logic          err;
    logic [1:0]    err_cause;
`endif

    always #5 clk = ~clk;

    sorted_list_ctrl_if #(.N(N), .KW(KW)) bus ();

    sorted_list_ctrl #(.N(N), .KW(KW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .o_head_vld (head_vld),
        .o_head_key (head_key),
        .o_count    (count),
        .o_full     (full),
        .o_empty    (empty)
`ifdef SORTED_LIST_ERR_EN
        ,
        .o_err       (err),
        .o_err_cause (err_cause)
`endif
    );

    typedef struct {
        int            lat;
        logic          ok;
        logic [KW-1:0] key;
        int            cnt;
        logic          hv;
        logic [KW-1:0] hk;
        logic          full;
        logic          empty;
    } obs_t;

    typedef struct {
        logic [1:0]    op;
        logic [KW-1:0] key;
        logic [2:0]    idx;
        logic          ok;
        logic [KW-1:0] rkey;
        int            cnt;
        logic [KW-1:0] head;
    } vec_t;

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   q[$];
    logic m_err     = 1'b0;
    logic [1:0] m_cause = 2'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: sorted queue, stable insert after equal keys
    task automatic model_cmd(input logic [1:0] op, input logic [KW-1:0] key, input logic [2:0] idx,
                             output logic ok, output logic [KW-1:0] rkey);
        int pos;
        ok   = 1'b1;
        rkey = '0;
        case (op)
            OP_INSERT: begin
                if (q.size() == N) ok = 1'b0;
                else begin
                    pos = q.size();
                    for (int i = 0; i < q.size(); i++) begin
                        if (q[i] > int'(key)) begin pos = i; break; end
                    end
                    q.insert(pos, int'(key));
                end
            end
            OP_POP: begin
                if (q.size() == 0) ok = 1'b0;
                else rkey = KW'(q.pop_front());
            end
            OP_DELETE: begin
                if (int'(idx) >= q.size()) ok = 1'b0;
                else begin rkey = KW'(q[idx]); q.delete(int'(idx)); end
            end
            default: begin q.delete(); m_err = 1'b0; m_cause = 2'd0; end
        endcase
        if (!ok && !m_err) begin
            m_err   = 1'b1;
            m_cause = (op == OP_INSERT) ? 2'd0 : (op == OP_POP) ? 2'd1 : 2'd2;
        end
    endtask

    // Issue one command (caller sits at a negedge); hold response for 'hold' cycles
    task automatic do_cmd(input logic [1:0] op, input logic [KW-1:0] key, input logic [2:0] idx,
                          input int hold, output obs_t o);
        int w = 0;
        while (bus.o_cmd_rdy !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        if (w >= 50) chk("accept_timeout", {63'd0, bus.o_cmd_rdy}, 64'd1);
        bus.i_cmd_vld = 1'b1; bus.i_cmd_op = op; bus.i_cmd_key = key; bus.i_cmd_idx = idx;
        @(posedge clk);
        @(negedge clk);
        // scramble the bus: the latched command must be used
        bus.i_cmd_vld = 1'b0;
        bus.i_cmd_op  = 2'($urandom);
        bus.i_cmd_key = KW'($urandom);
        bus.i_cmd_idx = 3'($urandom);
        o.lat = 1;
        while (bus.o_rsp_vld !== 1'b1 && o.lat < 20) begin @(negedge clk); o.lat++; end
        o.ok = bus.o_rsp_ok; o.key = bus.o_rsp_key; o.cnt = int'(count);
        o.hv = head_vld; o.hk = head_key; o.full = full; o.empty = empty;
        if (hold > 0) begin
            bus.i_cmd_vld = 1'b1; bus.i_cmd_op = OP_CLEAR;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("bp.rsp_vld", {63'd0, bus.o_rsp_vld}, 64'd1);
            chk("bp.rsp_ok",  {63'd0, bus.o_rsp_ok},  {63'd0, o.ok});
            chk("bp.rsp_key", {48'd0, bus.o_rsp_key}, {48'd0, o.key});
            chk("bp.cmd_rdy", {63'd0, bus.o_cmd_rdy}, 64'd0);
        end
        bus.i_cmd_vld = 1'b0;
        bus.i_rsp_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_rsp_rdy = 1'b0;
    endtask

    task automatic check_model(input string tag, input obs_t o, input logic eok,
                               input logic [KW-1:0] ekey, input int elat);
        chk({tag, ".lat"},   64'(o.lat), 64'(elat));
        chk({tag, ".ok"},    {63'd0, o.ok}, {63'd0, eok});
        chk({tag, ".key"},   {48'd0, o.key}, {48'd0, ekey});
        chk({tag, ".count"}, 64'(o.cnt), 64'(q.size()));
        chk({tag, ".hv"},    {63'd0, o.hv}, {63'd0, q.size() > 0});
        chk({tag, ".hk"},    {48'd0, o.hk}, (q.size() > 0) ? 64'(q[0]) : 64'd0);
        chk({tag, ".full"},  {63'd0, o.full}, {63'd0, q.size() == N});
        chk({tag, ".empty"}, {63'd0, o.empty}, {63'd0, q.size() == 0});
`ifdef SORTED_LIST_ERR_EN
        chk({tag, ".err"},   {63'd0, err}, {63'd0, m_err});
        chk({tag, ".cause"}, {62'd0, err_cause}, {62'd0, m_cause});
`endif
    endtask

    vec_t          vt[16];
    obs_t          o;
    logic          eok;
    logic [KW-1:0] ekey;
    logic [1:0]    rop;
    int            r;

    initial begin
        vt[0]  = '{OP_INSERT, 16'd5, 3'd0, 1'b1, 16'd0, 1, 16'd5};
        vt[1]  = '{OP_INSERT, 16'd3, 3'd0, 1'b1, 16'd0, 2, 16'd3};
        vt[2]  = '{OP_INSERT, 16'd9, 3'd0, 1'b1, 16'd0, 3, 16'd3};
        vt[3]  = '{OP_INSERT, 16'd5, 3'd0, 1'b1, 16'd0, 4, 16'd3};
        vt[4]  = '{OP_POP,    16'd0, 3'd0, 1'b1, 16'd3, 3, 16'd5};
        vt[5]  = '{OP_DELETE, 16'd0, 3'd1, 1'b1, 16'd5, 2, 16'd5};
        vt[6]  = '{OP_DELETE, 16'd0, 3'd2, 1'b0, 16'd0, 2, 16'd5};
        vt[7]  = '{OP_DELETE, 16'd0, 3'd0, 1'b1, 16'd5, 1, 16'd9};
        vt[8]  = '{OP_POP,    16'd0, 3'd0, 1'b1, 16'd9, 0, 16'd0};
        vt[9]  = '{OP_POP,    16'd0, 3'd0, 1'b0, 16'd0, 0, 16'd0};
        vt[10] = '{OP_INSERT, 16'd9, 3'd0, 1'b1, 16'd0, 1, 16'd9};
        vt[11] = '{OP_INSERT, 16'd3, 3'd0, 1'b1, 16'd0, 2, 16'd3};
        vt[12] = '{OP_INSERT, 16'd5, 3'd0, 1'b1, 16'd0, 3, 16'd3};
        vt[13] = '{OP_DELETE, 16'd0, 3'd1, 1'b1, 16'd5, 2, 16'd3};
        vt[14] = '{OP_DELETE, 16'd0, 3'd2, 1'b0, 16'd0, 2, 16'd3};
        vt[15] = '{OP_CLEAR,  16'd0, 3'd0, 1'b1, 16'd0, 0, 16'd0};

        rst = 1'b1;
        bus.i_cmd_vld = 1'b0; bus.i_cmd_op = 2'd0; bus.i_cmd_key = '0; bus.i_cmd_idx = '0;
        bus.i_rsp_rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst.cmd_rdy", {63'd0, bus.o_cmd_rdy}, 64'd1);
        chk("rst.rsp_vld", {63'd0, bus.o_rsp_vld}, 64'd0);
        chk("rst.rsp_ok",  {63'd0, bus.o_rsp_ok},  64'd0);
        chk("rst.rsp_key", {48'd0, bus.o_rsp_key}, 64'd0);
        chk("rst.head",    {47'd0, head_vld, head_key}, 64'd0);
        chk("rst.count",   {60'd0, count}, 64'd0);
        chk("rst.empty",   {62'd0, empty, full}, 64'd2);
`ifdef SORTED_LIST_ERR_EN
        chk("rst.err",     {61'd0, err, err_cause}, 64'd0);
`endif

        // Directed vector table
        for (int v = 0; v < 16; v++) begin
            do_cmd(vt[v].op, vt[v].key, vt[v].idx, 0, o);
            model_cmd(vt[v].op, vt[v].key, vt[v].idx, eok, ekey);
            chk($sformatf("v%0d.lat", v), 64'(o.lat), (vt[v].op == OP_CLEAR) ? 64'd2 : 64'd3);
            chk($sformatf("v%0d.ok", v),  {63'd0, o.ok}, {63'd0, vt[v].ok});
            chk($sformatf("v%0d.key", v), {48'd0, o.key}, {48'd0, vt[v].rkey});
            chk($sformatf("v%0d.cnt", v), 64'(o.cnt), 64'(vt[v].cnt));
            chk($sformatf("v%0d.hk", v),  {48'd0, o.hk}, {48'd0, vt[v].head});
`ifdef SORTED_LIST_ERR_EN
            chk($sformatf("v%0d.err", v), {63'd0, err}, {63'd0, m_err});
`endif
        end

        // Fill the table, then INSERT on full is rejected
        for (int i = 0; i < N; i++) begin
            ekey = KW'($urandom_range(2, 40));
            do_cmd(OP_INSERT, ekey, 3'd0, 0, o);
            model_cmd(OP_INSERT, ekey, 3'd0, eok, ekey);
            check_model("fill", o, eok, ekey, 3);
        end
        do_cmd(OP_INSERT, 16'd1, 3'd0, 0, o);
        model_cmd(OP_INSERT, 16'd1, 3'd0, eok, ekey);
        check_model("ins_full", o, eok, ekey, 3);
        chk("ins_full.ok0", {63'd0, o.ok}, 64'd0);
        chk("ins_full.full", {63'd0, full}, 64'd1);

        // CLEAR on a full table
        do_cmd(OP_CLEAR, 16'd0, 3'd0, 0, o);
        model_cmd(OP_CLEAR, 16'd0, 3'd0, eok, ekey);
        check_model("clear_full", o, eok, ekey, 2);
        chk("clear_full.empty", {63'd0, empty}, 64'd1);

        // Back-pressure: response held 5 cycles, accepted on the 6th
        do_cmd(OP_INSERT, 16'd7, 3'd0, 0, o);
        model_cmd(OP_INSERT, 16'd7, 3'd0, eok, ekey);
        do_cmd(OP_INSERT, 16'd4, 3'd0, 0, o);
        model_cmd(OP_INSERT, 16'd4, 3'd0, eok, ekey);
        do_cmd(OP_POP, 16'd0, 3'd0, 5, o);
        model_cmd(OP_POP, 16'd0, 3'd0, eok, ekey);
        check_model("bp", o, eok, ekey, 3);
        chk("bp.after_cnt", {60'd0, count}, 64'(q.size()));

        // Reset during PIVOT of an INSERT
        bus.i_cmd_vld = 1'b1; bus.i_cmd_op = OP_INSERT; bus.i_cmd_key = 16'd2; bus.i_cmd_idx = '0;
        @(posedge clk);
        @(negedge clk);
        bus.i_cmd_vld = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete(); m_err = 1'b0; m_cause = 2'd0;
        chk("rstmid.count",   {60'd0, count}, 64'd0);
        chk("rstmid.cmd_rdy", {63'd0, bus.o_cmd_rdy}, 64'd1);
        chk("rstmid.empty",   {63'd0, empty}, 64'd1);
        chk("rstmid.head_vld", {63'd0, head_vld}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("rstmid.no_rsp", {63'd0, bus.o_rsp_vld}, 64'd0);
            @(negedge clk);
        end

        // Randomized run against the reference model
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 19));
            rop = (r < 9) ? OP_INSERT : (r < 13) ? OP_POP : (r < 19) ? OP_DELETE : OP_CLEAR;
            ekey = KW'($urandom_range(0, 20));
            o.lat = 0;
            begin
                logic [2:0] ridx;
                logic [KW-1:0] k;
                k    = ekey;
                ridx = 3'($urandom_range(0, 7));
                do_cmd(rop, k, ridx, 0, o);
                model_cmd(rop, k, ridx, eok, ekey);
            end
            check_model($sformatf("rnd%0d", n), o, eok, ekey, (rop == OP_CLEAR) ? 2 : 3);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
